cr_fifoctrl_fwft: RTL and testbench
===================================

// Module: cr_fifoctrl_fwft
// PURPOSE
// Read-side first-word-fall-through prefetch stage for the FIFO controller.
// - Sits downstream of the read-side pointer tracker (empty-type instance).
// - Consumes that tracker's registered empty flag, and drives its increment.
// - Captures read data from the FIFO memory into a 2-entry output buffer.
// - Presents the data on a valid/ready interface at full rate, hiding memory read latency.
// PARAMETERS
// pDataWidth   8  width of memory read data and OutData
// pMemLatency  1  memory read latency in cycles after the address updates; legal values 0 or 1
// PORTS
// Clk        in   1           clock, all state on rising edge
// Rst_n      in   1           asynchronous active-low reset
// Empty      in   1           registered empty flag from read pointer tracker (1 = no word at current Addr)
// RdInc      out  1           combinational increment to read pointer tracker (pops one word)
// MemData    in   pDataWidth  FIFO memory read data for the current read address
// OutData    out  pDataWidth  head-of-buffer data, registered
// OutValid   out  1           OutData holds a valid word, registered
// OutReady   in   1           consumer accepts OutData this cycle when OutValid=1
// Occupancy  out  2           words held in output buffer (0..2), registered
// BEHAVIOUR
// - Reset (async, immediate): OutValid=0, OutData=0, Occupancy=0, in-flight count=0, skid entry invalid.
// - Pop = OutValid & OutReady. Push = a memory word returning this cycle.
// - With pMemLatency=0, Push=RdInc. With pMemLatency=1, Push=RdInc delayed 1 cycle.
//   The 1-bit in-flight register tracks that delayed RdInc.
// - RdInc = ~Empty & ((Occupancy + InFlight - Pop) < 2).
//   - The 2-bit arithmetic is widened to 3 bits to prevent wrap.
//   - The buffer never overflows.
//   - RdInc=0 whenever Empty=1. Empty resets high upstream, so RdInc=0 out of reset.
// - Capture timing:
//   - pMemLatency=0: MemData is sampled on the same edge that RdInc is high.
//   - pMemLatency=1: MemData is sampled on the edge one cycle after RdInc.
// - Latency: RdInc in cycle t gives OutValid=1 in cycle t+1+pMemLatency when the buffer was empty.
// - Buffer order is strict FIFO.
//   - Head register drives OutData. The skid register holds the second word.
//   - Push with empty head, or Push&Pop with only the head valid: MemData goes to head.
//   - Push with head valid and no Pop: MemData goes to skid.
//   - Pop with skid valid: skid moves to head. A simultaneous Push loads skid.
// - Occupancy_next = Occupancy + Push - Pop. Push with Occupancy=2 and no Pop cannot occur (guaranteed by RdInc rule).
// - OutData stays stable while OutValid=1 & OutReady=0.
// - OutValid never deasserts without a Pop.
// - Throughput: one word per cycle sustained when Empty=0 and OutReady=1, in both latency modes.
// - Empty rising while a word is in flight: the in-flight word is still captured and delivered.
//   No further RdInc is issued.
// - OutReady while OutValid=0 is ignored.
// - Reset mid-operation: buffered and in-flight words are discarded.
//   The read pointer tracker is reset by the same Rst_n.
// TESTING
// - Reset: assert Rst_n=0 with Occupancy=2 -> OutValid=0 and Occupancy=0 immediately.
//   After release with Empty=1 -> RdInc=0.
// - Single word (pMemLatency=1): Empty=0 for one word in cycle 0, MemData=8'hA5 in cycle 1
//   -> RdInc=1 in cycle 0, OutValid=1 and OutData=8'hA5 in cycle 2.
//   OutReady=1 in cycle 2 -> OutValid=0 in cycle 3.
// - Streaming: Empty=0, OutReady=1, MemData=0..15 -> OutData 0..15 on 16 consecutive cycles starting cycle 2.
//   No gaps, RdInc high every cycle.
// - Backpressure: OutReady=0 from the start of streaming -> exactly 2 RdInc pulses, Occupancy=2,
//   OutData=0 held stable. Raise OutReady -> 0,1,2,... in order, no loss, no duplicates.
// - Empty mid-stream: Empty rises the cycle after an RdInc -> the in-flight word is still delivered.
//   RdInc stays 0, and Occupancy drains to 0 with OutReady=1.
// - pMemLatency=0 variant: single word -> OutValid in cycle 1.
//   Streaming -> full rate. Backpressure -> Occupancy caps at 2.

Source files
------------

// File: rtl/cr_fifoctrl_fwft.sv
// First-word-fall-through read prefetch for the FIFO controller.
// Pulls words from memory into a 2-entry head/skid buffer behind a valid/ready port.
module cr_fifoctrl_fwft #(
    parameter int pDataWidth  = 8,
    parameter int pMemLatency = 1
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Empty,
    output logic                  RdInc,
    input  logic [pDataWidth-1:0] MemData,
    output logic [pDataWidth-1:0] OutData,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [1:0]            Occupancy
);

    logic                  pop;
    logic                  push;
    logic                  inFlight;
    logic                  skidValid;
    logic [pDataWidth-1:0] skidData;
    logic [2:0]            committed;

    assign pop = OutValid & OutReady;

    // Words already owned by the buffer once this cycle's pop retires.
    assign committed = {1'b0, Occupancy}
                     + {2'b00, inFlight}
                     - {2'b00, pop};

    assign RdInc = ~Empty & (committed < 3'd2);

    generate
        if (pMemLatency == 0) begin : gLat0
            assign inFlight = 1'b0;
            assign push     = RdInc;
        end else begin : gLat1
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    inFlight <= 1'b0;
                end else begin
                    inFlight <= RdInc;
                end
            end
            assign push = inFlight;
        end
    endgenerate

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            OutData   <= '0;
            OutValid  <= 1'b0;
            skidData  <= '0;
            skidValid <= 1'b0;
            Occupancy <= 2'd0;
        end else begin
            Occupancy <= Occupancy + {1'b0, push} - {1'b0, pop};
            unique case ({push, pop})
                2'b10: begin
                    if (!OutValid) begin
                        OutData  <= MemData;
                        OutValid <= 1'b1;
                    end else begin
                        skidData  <= MemData;
                        skidValid <= 1'b1;
                    end
                end
                2'b01: begin
                    if (skidValid) begin
                        OutData   <= skidData;
                        skidValid <= 1'b0;
                    end else begin
                        OutValid <= 1'b0;
                    end
                end
                2'b11: begin
                    if (skidValid) begin
                        OutData  <= skidData;
                        skidData <= MemData;
                    end else begin
                        OutData <= MemData;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cr_fifoctrl_fwft.sv
// Bench for cr_fifoctrl_fwft: both latency modes side by side,
// each fed by a small FIFO memory model with a scoreboard on the output port.
module tb_cr_fifoctrl_fwft;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       empty    [2];
    logic       rdInc    [2];
    logic       outValid [2];
    logic       rdy      [2];
    logic       wrEn     [2];
    logic [7:0] memData  [2];
    logic [7:0] outData  [2];
    logic [7:0] wrData   [2];
    logic [1:0] occ      [2];

    int passCnt  = 0;
    int totalCnt = 0;

    always #5 Clk = ~Clk;

    task automatic check(input string nm, input int act, input int exp);
        totalCnt++;
        if (act == exp) begin
            passCnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g
        logic [7:0] mem [64];
        logic [5:0] wp;
        logic [5:0] rp;
        logic [7:0] memQ;
        logic [7:0] expQ [$];

        cr_fifoctrl_fwft #(
            .pDataWidth (8),
            .pMemLatency(k)
        ) dut (
            .Clk      (Clk),
            .Rst_n    (Rst_n),
            .Empty    (empty[k]),
            .RdInc    (rdInc[k]),
            .MemData  (memData[k]),
            .OutData  (outData[k]),
            .OutValid (outValid[k]),
            .OutReady (rdy[k]),
            .Occupancy(occ[k])
        );

        // Memory plus read pointer tracker; lat-1 data is registered from the address.
        always @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                wp   <= '0;
                rp   <= '0;
                memQ <= '0;
            end else begin
                if (wrEn[k]) begin
                    mem[wp] <= wrData[k];
                    wp      <= wp + 6'd1;
                end
                if (rdInc[k]) rp <= rp + 6'd1;
                memQ <= mem[rp];
            end
        end

        assign empty[k]   = (wp == rp);
        assign memData[k] = (k == 0) ? mem[rp] : memQ;

        initial begin
            forever begin
                @(posedge Clk);
                if (Rst_n && wrEn[k]) expQ.push_back(wrData[k]);
                @(negedge Clk);
                if (!Rst_n) begin
                    expQ.delete();
                end else if (outValid[k] && rdy[k]) begin
                    check($sformatf("mon%0d_has_exp", k), int'(expQ.size() > 0), 1);
                    if (expQ.size() > 0)
                        check($sformatf("mon%0d_data", k), int'(outData[k]),
                              int'(expQ.pop_front()));
                end
            end
        end
    end

    task automatic nxt();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) nxt();
    endtask

    task automatic single(input int k);
        rdy[k]    = 1'b0;
        wrEn[k]   = 1'b1;
        wrData[k] = 8'hA5;
        @(negedge Clk);
        nxt();
        wrEn[k] = 1'b0;
        @(negedge Clk);
        check($sformatf("single%0d_rdinc_c0", k), int'(rdInc[k]), 1);
        check($sformatf("single%0d_valid_c0", k), int'(outValid[k]), 0);
        for (int c = 1; c < 1 + k; c++) begin
            nxt();
            @(negedge Clk);
            check($sformatf("single%0d_valid_early", k), int'(outValid[k]), 0);
            check($sformatf("single%0d_rdinc_c1", k), int'(rdInc[k]), 0);
        end
        nxt();
        rdy[k] = 1'b1;
        @(negedge Clk);
        check($sformatf("single%0d_valid", k), int'(outValid[k]), 1);
        check($sformatf("single%0d_data", k), int'(outData[k]), 8'hA5);
        check($sformatf("single%0d_occ", k), int'(occ[k]), 1);
        nxt();
        rdy[k] = 1'b0;
        @(negedge Clk);
        check($sformatf("single%0d_valid_after", k), int'(outValid[k]), 0);
        check($sformatf("single%0d_occ_after", k), int'(occ[k]), 0);
    endtask

    task automatic stream(input int k, input int n);
        rdy[k] = 1'b1;
        for (int c = -1; c <= n + k + 2; c++) begin
            if (c > -1) nxt();
            wrEn[k]   = (c <= n - 2);
            wrData[k] = 8'(c + 1);
            @(negedge Clk);
            if (c >= 0 && c < n)
                check($sformatf("stream%0d_%0d_rdinc", k, n), int'(rdInc[k]), 1);
            else if (c >= n)
                check($sformatf("stream%0d_%0d_rdinc_idle", k, n), int'(rdInc[k]), 0);
            if (c >= 1 + k && c <= n + k) begin
                check($sformatf("stream%0d_%0d_valid", k, n), int'(outValid[k]), 1);
                check($sformatf("stream%0d_%0d_data", k, n), int'(outData[k]), c - 1 - k);
            end else if (c > n + k) begin
                check($sformatf("stream%0d_%0d_drained", k, n), int'(outValid[k]), 0);
            end
        end
        check($sformatf("stream%0d_%0d_occ", k, n), int'(occ[k]), 0);
    endtask

    task automatic backpressure(input int k);
        int cnt;
        cnt    = 0;
        rdy[k] = 1'b0;
        for (int c = -1; c <= 9; c++) begin
            if (c > -1) nxt();
            wrEn[k]   = (c <= 6);
            wrData[k] = 8'(c + 1);
            @(negedge Clk);
            if (rdInc[k]) cnt++;
            if (c >= 1 + k) begin
                check($sformatf("bp%0d_valid", k), int'(outValid[k]), 1);
                check($sformatf("bp%0d_hold", k), int'(outData[k]), 0);
            end
        end
        check($sformatf("bp%0d_rdinc_cnt", k), cnt, 2);
        check($sformatf("bp%0d_occ_full", k), int'(occ[k]), 2);
        for (int c = 0; c < 14; c++) begin
            nxt();
            rdy[k]  = 1'b1;
            wrEn[k] = 1'b0;
            @(negedge Clk);
            if (rdInc[k]) cnt++;
        end
        check($sformatf("bp%0d_rdinc_total", k), cnt, 8);
        check($sformatf("bp%0d_occ_drained", k), int'(occ[k]), 0);
        check($sformatf("bp%0d_valid_drained", k), int'(outValid[k]), 0);
    endtask

    task automatic resetMid();
        for (int c = -1; c <= 6; c++) begin
            if (c > -1) nxt();
            for (int k = 0; k < 2; k++) begin
                rdy[k]    = 1'b0;
                wrEn[k]   = (c <= 2);
                wrData[k] = 8'(8'h41 + c);
            end
            @(negedge Clk);
        end
        for (int k = 0; k < 2; k++)
            check($sformatf("rst%0d_occ_before", k), int'(occ[k]), 2);
        nxt();
        #2;
        Rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst%0d_valid", k), int'(outValid[k]), 0);
            check($sformatf("rst%0d_occ", k), int'(occ[k]), 0);
            check($sformatf("rst%0d_data", k), int'(outData[k]), 0);
        end
        idle(2);
        Rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            for (int k = 0; k < 2; k++) begin
                check($sformatf("rst%0d_rdinc", k), int'(rdInc[k]), 0);
                check($sformatf("rst%0d_valid_after", k), int'(outValid[k]), 0);
            end
            nxt();
        end
    endtask

    initial begin
        Rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rdy[k]    = 1'b0;
            wrEn[k]   = 1'b0;
            wrData[k] = 8'h00;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("init%0d_valid", k), int'(outValid[k]), 0);
            check($sformatf("init%0d_occ", k), int'(occ[k]), 0);
            check($sformatf("init%0d_data", k), int'(outData[k]), 0);
        end
        idle(2);
        Rst_n = 1'b1;
        @(negedge Clk);
        for (int k = 0; k < 2; k++)
            check($sformatf("init%0d_rdinc", k), int'(rdInc[k]), 0);
        for (int k = 0; k < 2; k++) begin
            idle(1);
            single(k);
            idle(3);
            stream(k, 16);
            idle(3);
            stream(k, 3);
            idle(3);
            backpressure(k);
        end
        idle(2);
        resetMid();
        check("lat0_leftover", int'(g[0].expQ.size()), 0);
        check("lat1_leftover", int'(g[1].expQ.size()), 0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
